ifetch_data_stage: RTL
======================

// Module: ifetch_data_stage
// PURPOSE
//  Second ifetch stage, downstream of ifetch_tag_stage. Holds one {pc, warp_idx} entry and compares its tag against the
//  set tags read in the previous cycle. Hit: selects the way's instruction word and forwards it to decode.
//  Miss: reports to the tag stage (warp sleeps) and issues a line request to L2 through a one-entry request register.
// PARAMETERS
//  NUM_WARP_PER_CORE      4   warps per core; NUM_WARP_PER_CORE_LOG = $clog2
//  ADDR_WIDTH             32  pc width
//  L1_CACHE_NUM_SETS_LOG  6   set index bits; set = pc[6 +: 6] (64-byte lines)
//  L1_CACHE_NUM_WAYS      4   associativity; tag = pc[ADDR_WIDTH-1:12]
// PORTS
//  clk                      in   1        clock
//  rst                      in   1        synchronous reset, active high
//  ift_to_ifd_valid         in   1        tag-stage entry valid
//  ift_to_ifd_bus           in   A+W      {pc, warp_idx}
//  ifd_allowin              out  1        stage can accept an entry this cycle
//  icache_tag_valid         in   WAYS     per-way valid of set read last cycle
//  icache_tag               in   WAYS*20  per-way tags, way 0 in LSBs
//  icache_inst              in   WAYS*32  per-way instruction word at pc[5:2]
//  ifd_cache_miss           out  1        miss retired this cycle
//  ifd_near_miss            out  1        miss retired, but line filled this cycle
//  ifd_cache_miss_warp_idx  out  W        warp of the retiring miss
//  l2i_fill_en              in   1        L2 fill writes a line this cycle
//  l2i_fill_addr            in   A        line address of that fill
//  ifd_to_l2i_req_valid     out  1        line request pending
//  ifd_to_l2i_req_addr      out  A        line address, pc & ~'h3f
//  l2i_req_ready            in   1        L2 accepts the request
//  id_allowin               in   1        decode can accept
//  ifd_to_id_valid          out  1        instruction valid to decode
//  ifd_to_id_bus            out  32+A+W   {inst, pc, warp_idx}
//  wb_rollback_en           in   1        rollback
//  wb_rollback_warp_idx     in   W        warp being rolled back
// BEHAVIOUR
//  - Reset: entry valid=0, output valid=0, req_valid=0, req_addr=0, ifd_to_id_bus=0; miss, near_miss and warp_idx=0.
//  - Handshake: ifd_allowin = !v_r || (ready_go && out_ok). out_ok = !ifd_to_id_valid || id_allowin.
//    Load {pc, warp} when ift_to_ifd_valid && ifd_allowin.
//  - Hit: a way has valid && tag match. Lowest-index way wins on multi-hit. inst = that way's word.
//    ready_go=1. On the edge with out_ok, ifd_to_id_valid<=1 and the bus is loaded: latency 1 cycle after accept.
//  - Output register: cleared when id_allowin and no new hit is loaded.
//  - Miss, no same-line fill: ready_go = !req_valid || req_addr==line.
//    * Retires: ifd_cache_miss=1 (combinational, one cycle) with warp idx. Entry is dropped and not forwarded.
//    * req_valid was 0: req_valid<=1, req_addr<=line. Same line: merge, no new request.
//    * Different line pending: ready_go=0, ifd_allowin=0, entry stalls until the request is accepted.
//  - Near miss: miss and l2i_fill_en && fill_addr==line this cycle. Retires with ifd_cache_miss=1, ifd_near_miss=1.
//    No request is issued (tag stage refetches without sleeping).
//  - Request register: req_valid cleared on the edge where req_valid && l2i_req_ready.
//    A new miss may load it in that same cycle: accept and load are simultaneous.
//  - Rollback: wb_rollback_en && warp==entry warp, entry valid. Entry is invalidated at the edge.
//    No miss, near-miss or forward. Rollback outranks hit and miss that cycle.
//    An already-issued request stays pending. The output register is not flushed (decode owns that).
//  - rst mid-operation: drops entry, output and pending request the next edge.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined: 32-bit outputs perf_icache_hit_cnt and perf_icache_miss_cnt.
//    Hit counts each hit forwarded. Miss counts each miss retired; near-miss counts as miss.
//    Both wrap at 2^32 and clear on rst.
//  Not defined: ports and counters are absent.
// TESTING
//  1 reset then pc=0x0 warp0, way1 tag match, id_allowin=1 -> next cycle ifd_to_id_valid=1, bus={way1 inst,0x0,0}.
//  2 pc=0x40 warp2 all ways mismatch -> ifd_cache_miss=1, warp_idx=2; req_valid=1, addr=0x40; no id_valid.
//  3 req 0x40 pending, l2i_req_ready=0; miss pc=0x44 warp1 -> merged, miss=1.
//    Miss pc=0x80 -> ifd_allowin=0 until ready=1, then req_addr=0x80.
//  4 miss pc=0xC0 with l2i_fill_en, fill_addr=0xC0 same cycle -> miss=1, near_miss=1, req_valid stays 0.
//  5 hit entry warp3 with id_allowin=0 -> held, ifd_allowin=0.
//    wb_rollback_en warp3 -> entry dropped, no forward, ifd_allowin=1.
//  6 IFETCH_PERF_CNT_EN: 3 hits + 2 misses (1 near) -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/ifetch_data_stage_if.sv
// Signal bundle between ifetch_data_stage and its neighbours (tag stage, icache arrays, L2, decode, writeback).
// The master modport is the environment side; the slave modport is the data stage itself.
interface ifetch_data_stage_if #(
  parameter int NUM_WARP_PER_CORE     = 4,
  parameter int ADDR_WIDTH            = 32,
  parameter int L1_CACHE_NUM_SETS_LOG = 6,
  parameter int L1_CACHE_NUM_WAYS     = 4
);
  localparam int NUM_WARP_PER_CORE_LOG = $clog2(NUM_WARP_PER_CORE);
  localparam int TAG_W                 = ADDR_WIDTH - 6 - L1_CACHE_NUM_SETS_LOG;

  logic                                        ift_to_ifd_valid;
  logic [ADDR_WIDTH+NUM_WARP_PER_CORE_LOG-1:0] ift_to_ifd_bus;
  logic                                        ifd_allowin;
  logic [L1_CACHE_NUM_WAYS-1:0]                icache_tag_valid;
  logic [L1_CACHE_NUM_WAYS*TAG_W-1:0]          icache_tag;
  logic [L1_CACHE_NUM_WAYS*32-1:0]             icache_inst;
  logic                                        ifd_cache_miss;
  logic                                        ifd_near_miss;
  logic [NUM_WARP_PER_CORE_LOG-1:0]            ifd_cache_miss_warp_idx;
  logic                                        l2i_fill_en;
  logic [ADDR_WIDTH-1:0]                       l2i_fill_addr;
  logic                                        ifd_to_l2i_req_valid;
  logic [ADDR_WIDTH-1:0]                       ifd_to_l2i_req_addr;
  logic                                        l2i_req_ready;
  logic                                        id_allowin;
  logic                                        ifd_to_id_valid;
  logic [32+ADDR_WIDTH+NUM_WARP_PER_CORE_LOG-1:0] ifd_to_id_bus;
  logic                                        wb_rollback_en;
  logic [NUM_WARP_PER_CORE_LOG-1:0]            wb_rollback_warp_idx;

  modport master (
    output ift_to_ifd_valid, ift_to_ifd_bus, icache_tag_valid, icache_tag, icache_inst,
           l2i_fill_en, l2i_fill_addr, l2i_req_ready, id_allowin,
           wb_rollback_en, wb_rollback_warp_idx,
    input  ifd_allowin, ifd_cache_miss, ifd_near_miss, ifd_cache_miss_warp_idx,
           ifd_to_l2i_req_valid, ifd_to_l2i_req_addr, ifd_to_id_valid, ifd_to_id_bus
  );

  modport slave (
    input  ift_to_ifd_valid, ift_to_ifd_bus, icache_tag_valid, icache_tag, icache_inst,
           l2i_fill_en, l2i_fill_addr, l2i_req_ready, id_allowin,
           wb_rollback_en, wb_rollback_warp_idx,
    output ifd_allowin, ifd_cache_miss, ifd_near_miss, ifd_cache_miss_warp_idx,
           ifd_to_l2i_req_valid, ifd_to_l2i_req_addr, ifd_to_id_valid, ifd_to_id_bus
  );
endinterface

// File: rtl/ifetch_data_stage.sv
// Second ifetch stage: tag compare, hit forwarding to decode, miss reporting and a one-entry L2 line request.
// Optional performance counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_data_stage #(
  parameter int NUM_WARP_PER_CORE     = 4,
  parameter int ADDR_WIDTH            = 32,
  parameter int L1_CACHE_NUM_SETS_LOG = 6,
  parameter int L1_CACHE_NUM_WAYS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ifetch_data_stage_if.slave   bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_icache_hit_cnt,
  output logic [31:0]          perf_icache_miss_cnt
`endif
);
  localparam int WL       = $clog2(NUM_WARP_PER_CORE);
  localparam int LINE_OFF = 6;
  localparam int TAG_LSB  = LINE_OFF + L1_CACHE_NUM_SETS_LOG;
  localparam int TAG_W    = ADDR_WIDTH - TAG_LSB;

  logic                       r_valid;
  logic [ADDR_WIDTH-1:0]      r_pc;
  logic [WL-1:0]              r_warp;
  logic                       r_out_valid;
  logic [32+ADDR_WIDTH+WL-1:0] r_out_bus;
  logic                       r_req_valid;
  logic [ADDR_WIDTH-1:0]      r_req_addr;

  logic                       w_hit;
  logic [31:0]                w_inst;
  logic [ADDR_WIDTH-1:0]      w_line;
  logic                       w_rollback;
  logic                       w_fill_same_line;
  logic                       w_same_req;
  logic                       w_req_free;
  logic                       w_ready_go;
  logic                       w_out_ok;
  logic                       w_retire;
  logic                       w_fwd;
  logic                       w_miss;
  logic                       w_issue;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_hit  = 1'b0;
    w_inst = '0;
    // Scan from the top way down so the lowest matching way is the one left standing.
    for (int i = L1_CACHE_NUM_WAYS - 1; i >= 0; i--) begin
      if (bus.icache_tag_valid[i] && (bus.icache_tag[i*TAG_W +: TAG_W] == r_pc[ADDR_WIDTH-1:TAG_LSB])) begin
        w_hit  = 1'b1;
        w_inst = bus.icache_inst[i*32 +: 32];
      end
    end
  end

  assign w_line           = {r_pc[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign w_rollback       = bus.wb_rollback_en && r_valid && (bus.wb_rollback_warp_idx == r_warp);
  assign w_fill_same_line = bus.l2i_fill_en && (bus.l2i_fill_addr == w_line);
  assign w_same_req       = r_req_valid && (r_req_addr == w_line);
  // A different pending line frees up in the same cycle L2 accepts it, so the new miss can load behind it.
  assign w_req_free       = !r_req_valid || w_same_req || bus.l2i_req_ready;
  assign w_ready_go       = w_hit || w_fill_same_line || w_req_free;
  assign w_out_ok         = !r_out_valid || bus.id_allowin;
  assign w_retire         = r_valid && !w_rollback && w_ready_go && w_out_ok;
  assign w_fwd            = w_retire && w_hit;
  assign w_miss           = w_retire && !w_hit;
  assign w_issue          = w_miss && !w_fill_same_line && !w_same_req;

  assign bus.ifd_allowin             = !r_valid || (w_ready_go && w_out_ok);
  assign bus.ifd_cache_miss          = w_miss;
  assign bus.ifd_near_miss           = w_miss && w_fill_same_line;
  assign bus.ifd_cache_miss_warp_idx = w_miss ? r_warp : '0;
  assign bus.ifd_to_l2i_req_valid    = r_req_valid;
  assign bus.ifd_to_l2i_req_addr     = r_req_addr;
  assign bus.ifd_to_id_valid         = r_out_valid;
  assign bus.ifd_to_id_bus           = r_out_bus;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_warp      <= '0;
      r_out_valid <= 1'b0;
      r_out_bus   <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
    end else begin
      if (bus.ifd_allowin) begin
        r_valid <= bus.ift_to_ifd_valid;
        if (bus.ift_to_ifd_valid) begin
          r_pc   <= bus.ift_to_ifd_bus[WL +: ADDR_WIDTH];
          r_warp <= bus.ift_to_ifd_bus[WL-1:0];
        end
      end else if (w_rollback) begin
        r_valid <= 1'b0;
      end

      if (w_fwd) begin
        r_out_valid <= 1'b1;
        r_out_bus   <= {w_inst, r_pc, r_warp};
      end else if (bus.id_allowin) begin
        r_out_valid <= 1'b0;
      end

      if (w_issue) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= w_line;
      end else if (r_req_valid && bus.l2i_req_ready) begin
        r_req_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_fwd)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign perf_icache_hit_cnt  = r_hit_cnt;
  assign perf_icache_miss_cnt = r_miss_cnt;
`endif

endmodule
